mem_access_seq: RTL and testbench
=================================

// Module: mem_access_seq
// PURPOSE
//  Memory-access sequencer between the control unit and external data memory.
//  On a read or write command it runs one handshaked bus cycle:
//   - the address comes from the MAR;
//   - write data comes from the MDR's data_bus_out;
//   - read data goes to the MDR's data_bus_in, with an mdr_en load strobe.
//  Adds wait-state tolerance and an ack timeout, so the MDR only ever sees stable data.
// PARAMETERS
//  DATA_WIDTH      8   data bus width
//  ADDR_WIDTH      8   address bus width
//  TIMEOUT_CYCLES  15  max cycles in REQ without mem_ack before abort (>=1)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  rd_req     in   1           read command, sampled only in IDLE
//  wr_req     in   1           write command, sampled only in IDLE
//  addr_in    in   ADDR_WIDTH  address from MAR
//  wr_data    in   DATA_WIDTH  write data from MDR data_bus_out
//  mem_rdata  in   DATA_WIDTH  memory read data, valid when mem_ack=1
//  mem_ack    in   1           memory completion, may arrive any cycle cs=1
//  mem_addr   out  ADDR_WIDTH  registered address to memory
//  mem_wdata  out  DATA_WIDTH  registered write data to memory
//  mem_cs     out  1           chip select, high for the whole REQ state
//  mem_we     out  1           1=write, 0=read; valid while mem_cs=1
//  rd_data    out  DATA_WIDTH  captured read data, to MDR data_bus_in
//  mdr_en     out  1           1-cycle MDR load strobe, read completion only
//  busy       out  1           high in every state except IDLE
//  done       out  1           1-cycle pulse on successful completion
//  err        out  1           1-cycle pulse on timeout or illegal command
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0, including mem_cs, which drops immediately.
//    A transaction in flight is abandoned; no done and no err after release.
//  States: IDLE, REQ, DONE, ERR. All outputs are registered.
//  IDLE:
//   - rd_req XOR wr_req: latch addr_in->mem_addr and wr_data->mem_wdata (write only);
//     set mem_we=wr_req; clear timer; go to REQ.
//   - rd_req AND wr_req in the same cycle: illegal. Go to ERR; no bus cycle.
//   - mem_ack in IDLE is ignored.
//  REQ:
//   - mem_cs=1. mem_addr, mem_wdata and mem_we are held constant.
//   - Commands arriving while busy are dropped, not queued.
//   - mem_ack=1 on a read: rd_data<=mem_rdata; go to DONE.
//   - mem_ack=1 on a write: go to DONE; rd_data unchanged.
//   - No ack: timer increments. When the timer reaches TIMEOUT_CYCLES-1 with no ack, go to ERR.
//   - Ack on the same cycle as the timeout: the ack wins.
//  DONE:
//   - mem_cs=0; done=1; mdr_en=1 if the cycle was a read. Go to IDLE next cycle.
//  ERR:
//   - mem_cs=0; err=1; mdr_en=0; rd_data keeps its previous value. Go to IDLE.
//  Latency:
//   - Command sampled at edge N -> mem_cs high after N.
//   - Ack sampled at edge N+k (k>=1) -> done/mdr_en high after N+k for exactly one cycle.
//   - Best case is a 3-cycle round trip: command to done.
//   - rd_data is stable from DONE until the next read completes, so the MDR latches at edge N+k+1.
//   - A new command is accepted no earlier than the cycle after DONE/ERR.
//  Timer: $clog2(TIMEOUT_CYCLES+1) bits, saturating, cleared on entry to REQ.
// STRUCTURE
//  Package pdua_mem_pkg:
//   - state enum {IDLE,REQ,DONE,ERR}
//   - TIMER_W localparam function
//  Sub-module mem_wait_timer:
//   - inputs: clr, en
//   - output: expired
//   - parameter: TIMEOUT_CYCLES
//  The FSM and the output registers stay in mem_access_seq.
// TESTING
//  1 Read, 0 wait: addr_in=8'h3C, rd_req pulse, ack on first cs cycle with mem_rdata=8'hA5
//    -> mem_addr=3C, mem_we=0; done+mdr_en one cycle; rd_data=A5.
//  2 Write, 3 waits: addr_in=8'h10, wr_data=8'h5A, wr_req
//    -> cs held 4 cycles with addr/wdata stable; done=1; mdr_en=0; rd_data unchanged.
//  3 Timeout: rd_req, no ack
//    -> cs high exactly TIMEOUT_CYCLES cycles; err=1 one cycle; rd_data unchanged;
//       ack on the timeout cycle gives done instead.
//  4 Illegal/busy: rd_req=wr_req=1 -> err pulse, mem_cs never high;
//    a new rd_req during REQ is ignored, only one bus cycle occurs.
//  5 Reset mid-REQ: rst_n=0 between edges -> mem_cs/busy fall asynchronously;
//    after release: IDLE, no done/err, late ack ignored.

Source files
------------

// File: rtl/pdua_mem_pkg.sv
// Shared types and sizing helpers for the memory-access sequencer.
package pdua_mem_pkg;

  // Sequencer states: one handshaked bus cycle runs IDLE -> REQ -> DONE/ERR -> IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Width of the wait-state timer. One extra code lets it saturate one past
  // the last legal wait count without wrapping back to zero.
  function automatic int timer_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_ack and flags the last permitted cycle.
module mem_wait_timer
  import pdua_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int                 TIMER_W = timer_w(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] LAST    = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SAT     = TIMER_W'(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear wins, otherwise count up while enabled and saturate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != SAT)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The current wait cycle is the last one allowed before an abort.
  assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_access_seq.sv
// Memory-access sequencer: turns a read or write command from the control
// unit into one handshaked bus cycle with wait-state tolerance and an ack
// timeout. Read data is captured once and held so the MDR always sees a
// stable value. Every output comes straight from a register.
module mem_access_seq
  import pdua_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mdr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q,    mem_we_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                  mem_cs_q,    mem_cs_d;
  logic                  mdr_en_q,    mdr_en_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  err_q,       err_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  // The timer only runs while waiting for an ack; outside REQ it is held at
  // zero, so every bus cycle starts counting from a fresh timer.
  assign timer_clr = (state_q != REQ);
  assign timer_en  = (state_q == REQ);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // Next-state logic, plus next values for the latched bus fields and flags.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rd_data_d   = rd_data_q;

    unique case (state_q)
      IDLE: begin
        // A read and a write together is illegal: report it, start no bus cycle.
        if (rd_req && wr_req) begin
          state_d = ERR;
        end else if (rd_req || wr_req) begin
          state_d    = REQ;
          mem_addr_d = addr_in;
          mem_we_d   = wr_req;
          if (wr_req) begin
            mem_wdata_d = wr_data;
          end
        end
      end
      REQ: begin
        // An ack on the last allowed wait cycle still completes the transfer.
        if (mem_ack) begin
          state_d = DONE;
          if (!mem_we_q) begin
            rd_data_d = mem_rdata;
          end
        end else if (timer_expired) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are decoded from the next state so they appear in the
    // same cycle as the state they describe.
    mem_cs_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    err_d    = (state_d == ERR);
    mdr_en_d = (state_d == DONE) && (state_q == REQ) && !mem_we_q;
  end

  // State and output registers; reset drops chip select immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_data_q   <= '0;
      mem_cs_q    <= 1'b0;
      mdr_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_data_q   <= rd_data_d;
      mem_cs_q    <= mem_cs_d;
      mdr_en_q    <= mdr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rd_data   = rd_data_q;
  assign mem_cs    = mem_cs_q;
  assign mdr_en    = mdr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: a transaction-level model predicts
// every output each cycle, and directed scenarios pin key values by hand.
module tb_mem_access_seq;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int TMO = 15;

  logic          clk;
  logic          rst_n;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_cs;
  logic          mem_we;
  logic [DW-1:0] rd_data;
  logic          mdr_en;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  mem_access_seq #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .addr_in  (addr_in),
    .wr_data  (wr_data),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .rd_data  (rd_data),
    .mdr_en   (mdr_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A bus transfer is "open" from the accepting edge until an ack or until
  // chip select has been high for TMO cycles. After a transfer closes (or an
  // illegal command) there is one status cycle reporting done or err.
  bit          m_open;
  int          m_cs_cycles;   // cycles chip select has been high so far
  int          m_status;      // 0 none, 1 done, 2 err
  bit          m_was_read;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [DW-1:0] m_rd_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 0; m_cs_cycles = 0; m_status = 0; m_was_read = 0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; m_rd_data = '0;
    end else if (m_open) begin
      m_cs_cycles++;
      if (mem_ack) begin
        m_open = 0; m_status = 1; m_was_read = !m_we;
        if (!m_we) m_rd_data = mem_rdata;
      end else if (m_cs_cycles >= TMO) begin
        m_open = 0; m_status = 2; m_was_read = 0;
      end
    end else if (m_status != 0) begin
      m_status = 0; m_was_read = 0;   // commands during the status cycle are dropped
    end else if (rd_req && wr_req) begin
      m_status = 2;
    end else if (rd_req || wr_req) begin
      m_open = 1; m_cs_cycles = 0; m_addr = addr_in; m_we = wr_req;
      if (wr_req) m_wdata = wr_data;
    end
  end

  // ---------------- compare + observation counters ----------------
  int   cs_cycles_seen = 0;
  int   cs_starts      = 0;
  int   done_seen      = 0;
  int   err_seen       = 0;
  int   mdr_seen       = 0;
  logic cs_prev        = 1'b0;

  always @(negedge clk) begin
    check("mem_cs", 32'(mem_cs), 32'(m_open));
    check("busy",   32'(busy),   32'(m_open || (m_status != 0)));
    check("done",   32'(done),   32'(m_status == 1));
    check("err",    32'(err),    32'(m_status == 2));
    check("mdr_en", 32'(mdr_en), 32'((m_status == 1) && m_was_read));
    check("mem_addr",  32'(mem_addr),  32'(m_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("mem_we",    32'(mem_we),    32'(m_we));
    check("rd_data",   32'(rd_data),   32'(m_rd_data));
    cs_cycles_seen += int'(mem_cs === 1'b1);
    done_seen      += int'(done === 1'b1);
    err_seen       += int'(err === 1'b1);
    mdr_seen       += int'(mdr_en === 1'b1);
    if (mem_cs === 1'b1 && cs_prev !== 1'b1) cs_starts++;
    cs_prev = mem_cs;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
  endtask

  int cs0, st0, d0, e0, m0;

  task automatic snap();
    cs0 = cs_cycles_seen; st0 = cs_starts; d0 = done_seen; e0 = err_seen; m0 = mdr_seen;
  endtask

  initial begin
    rst_n = 1'b0; quiet(); addr_in = '0; wr_data = '0; mem_rdata = '0;
    tick(3);
    check("reset_cs",   32'(mem_cs),  32'd0);
    check("reset_busy", 32'(busy),    32'd0);
    check("reset_rd",   32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: read, zero wait states
    snap();
    addr_in = 8'h3C; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hA5;
    check("t1_addr", 32'(mem_addr), 32'h3C);
    check("t1_we",   32'(mem_we),   32'd0);
    tick(1);
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("t1_done_now", 32'(done),   32'd1);
    check("t1_mdr_now",  32'(mdr_en), 32'd1);
    tick(2);
    check("t1_rd_data", 32'(rd_data), 32'hA5);
    check("t1_cs_cyc",  32'(cs_cycles_seen - cs0), 32'd1);
    check("t1_done",    32'(done_seen - d0), 32'd1);
    check("t1_mdr",     32'(mdr_seen - m0),  32'd1);

    // 2: write, three wait states
    snap();
    addr_in = 8'h10; wr_data = 8'h5A; wr_req = 1'b1;
    tick(1);
    wr_req = 1'b0; addr_in = 8'hFF; wr_data = 8'h00; mem_rdata = 8'hEE;
    tick(3);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    tick(2);
    check("t2_addr",    32'(mem_addr),  32'h10);
    check("t2_wdata",   32'(mem_wdata), 32'h5A);
    check("t2_we",      32'(mem_we),    32'd1);
    check("t2_cs_cyc",  32'(cs_cycles_seen - cs0), 32'd4);
    check("t2_done",    32'(done_seen - d0), 32'd1);
    check("t2_mdr",     32'(mdr_seen - m0),  32'd0);
    check("t2_rd_data", 32'(rd_data), 32'hA5);

    // 3a: read timeout
    snap();
    addr_in = 8'h77; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    tick(TMO + 3);
    check("t3_cs_cyc",  32'(cs_cycles_seen - cs0), 32'(TMO));
    check("t3_err",     32'(err_seen - e0),  32'd1);
    check("t3_done",    32'(done_seen - d0), 32'd0);
    check("t3_rd_data", 32'(rd_data), 32'hA5);

    // 3b: ack on the timeout cycle wins
    snap();
    addr_in = 8'h78; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    tick(TMO - 1);
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick(1);
    mem_ack = 1'b0;
    tick(2);
    check("t3b_cs_cyc", 32'(cs_cycles_seen - cs0), 32'(TMO));
    check("t3b_done",   32'(done_seen - d0), 32'd1);
    check("t3b_err",    32'(err_seen - e0),  32'd0);
    check("t3b_rd",     32'(rd_data), 32'hC3);

    // 4a: illegal simultaneous command
    snap();
    addr_in = 8'h01; rd_req = 1'b1; wr_req = 1'b1;
    tick(1);
    quiet();
    tick(2);
    check("t4_err",    32'(err_seen - e0), 32'd1);
    check("t4_cs_cyc", 32'(cs_cycles_seen - cs0), 32'd0);

    // 4b: command during REQ is dropped
    snap();
    addr_in = 8'h20; rd_req = 1'b1;
    tick(1);
    addr_in = 8'h99;
    tick(2);
    rd_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h3E;
    tick(1);
    mem_ack = 1'b0;
    tick(3);
    check("t4_starts", 32'(cs_starts - st0), 32'd1);
    check("t4_addr",   32'(mem_addr), 32'h20);
    check("t4_rd",     32'(rd_data),  32'h3E);

    // 5: reset in the middle of REQ
    snap();
    addr_in = 8'h44; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    tick(2);
    check("t5_cs_before", 32'(mem_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_async",   32'(mem_cs), 32'd0);
    check("t5_busy_async", 32'(busy),   32'd0);
    tick(2);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h66;
    tick(2);
    mem_ack = 1'b0;
    tick(2);
    check("t5_done", 32'(done_seen - d0), 32'd0);
    check("t5_err",  32'(err_seen - e0),  32'd0);
    check("t5_rd",   32'(rd_data), 32'd0);

    // recovery read after reset
    addr_in = 8'h55; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h81;
    tick(1);
    mem_ack = 1'b0;
    tick(2);
    check("t5_recover_rd", 32'(rd_data), 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
